// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable word format, one-word holding
// register with overrun detection, break detection and line-idle indication.
module uart_rx_cfg #(
    parameter int ClkFrequency = 24000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16,
    parameter int DataBits     = 8,
    parameter int Parity       = 0,
    parameter int StopBits     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RxD,
    output logic [DataBits-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun_err,
    output logic                break_det,
    output logic                rx_idle
);

    localparam int Div    = (ClkFrequency + (Baud * Oversampling) / 2) / (Baud * Oversampling);
    localparam int DivW   = (Div > 1) ? $clog2(Div) : 1;
    localparam int TickW  = $clog2(Oversampling);
    localparam int BitW   = $clog2(DataBits + 1);
    localparam int GapW   = $clog2(2 * Oversampling + 1);

    localparam logic [DivW-1:0]  DivLast  = DivW'(Div - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(Oversampling / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(Oversampling - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DataBits - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(StopBits - 1);
    localparam logic [GapW-1:0]  GapMax   = GapW'(2 * Oversampling);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t              state, stateNext;
    logic [DivW-1:0]     divCnt;
    logic                tick;
    logic [1:0]          syncReg;
    logic                rxBit;
    logic [TickW-1:0]    tickCnt, tickCntNext;
    logic [BitW-1:0]     bitCnt, bitCntNext;
    logic [DataBits-1:0] shiftReg, shiftNext;
    logic                parBit, parBitNext;
    logic                stopErr, stopErrNext;
    logic                complete, compFerr, isBreak;
    logic                parSum, parErrNow;
    logic [GapW-1:0]     gapCnt;

    assign tick  = (divCnt == DivLast);
    assign rxBit = syncReg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt  <= '0;
            syncReg <= 2'b11;
        end else begin
            divCnt  <= tick ? '0 : divCnt + 1'b1;
            syncReg <= {syncReg[0], RxD};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tickCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            parBit   <= 1'b0;
            stopErr  <= 1'b0;
        end else begin
            state    <= stateNext;
            tickCnt  <= tickCntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            parBit   <= parBitNext;
            stopErr  <= stopErrNext;
        end
    end

    always_comb begin
        stateNext   = state;
        tickCntNext = tickCnt;
        bitCntNext  = bitCnt;
        shiftNext   = shiftReg;
        parBitNext  = parBit;
        stopErrNext = stopErr;
        complete    = 1'b0;
        compFerr    = stopErr;
        isBreak     = 1'b0;
        case (state)
            IDLE: begin
                if (!rxBit) begin
                    stateNext   = START;
                    tickCntNext = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tickCnt == TickHalf) begin
                        tickCntNext = '0;
                        if (rxBit) begin
                            stateNext = IDLE;
                        end else begin
                            stateNext   = DATA;
                            bitCntNext  = '0;
                            parBitNext  = 1'b0;
                            stopErrNext = 1'b0;
                        end
                    end else begin
                        tickCntNext = tickCnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tickCnt == TickLast) begin
                        tickCntNext = '0;
                        shiftNext   = {rxBit, shiftReg[DataBits-1:1]};
                        if (bitCnt == DataLast) begin
                            bitCntNext = '0;
                            stateNext  = (Parity != 0) ? PARITY : STOP;
                        end else begin
                            bitCntNext = bitCnt + 1'b1;
                        end
                    end else begin
                        tickCntNext = tickCnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (tickCnt == TickLast) begin
                        tickCntNext = '0;
                        parBitNext  = rxBit;
                        stateNext   = STOP;
                    end else begin
                        tickCntNext = tickCnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tickCnt == TickLast) begin
                        tickCntNext = '0;
                        compFerr    = stopErr | ~rxBit;
                        stopErrNext = compFerr;
                        if (bitCnt == StopLast) begin
                            complete   = 1'b1;
                            bitCntNext = '0;
                            // An all-zero frame with a bad stop bit is a held-low line
                            if ((shiftReg == '0) && !parBit && compFerr) begin
                                isBreak   = 1'b1;
                                stateNext = BREAK_WAIT;
                            end else begin
                                stateNext = IDLE;
                            end
                        end else begin
                            bitCntNext = bitCnt + 1'b1;
                        end
                    end else begin
                        tickCntNext = tickCnt + 1'b1;
                    end
                end
            end
            BREAK_WAIT: begin
                if (!rxBit) begin
                    tickCntNext = '0;
                end else if (tick) begin
                    if (tickCnt == TickLast) begin
                        tickCntNext = '0;
                        stateNext   = IDLE;
                    end else begin
                        tickCntNext = tickCnt + 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign parSum    = ^{shiftReg, parBit};
    assign parErrNow = (Parity == 1) ? ~parSum : ((Parity == 2) ? parSum : 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            break_det   <= isBreak;
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shiftReg;
                    parity_err <= parErrNow;
                    frame_err  <= compFerr;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gapCnt <= '0;
        end else if (state != IDLE) begin
            gapCnt <= '0;
        end else if (tick && (gapCnt != GapMax)) begin
            gapCnt <= gapCnt + 1'b1;
        end
    end

    assign rx_idle = (gapCnt == GapMax);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance driven with
// directed frames, checked against a frame-level scoreboard model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int DIV = 13;   // round(24e6 / (115200*16))
    localparam int OS  = 16;
    localparam int BIT = DIV * OS;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         startCyc;
        bit         chkLat;
        int         nBits;
    } expT;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rxd [2];
    logic       ready [2];
    logic [7:0] data0;
    logic [6:0] data1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1;
    logic       ovr0, ovr1, brk0, brk1, idle0, idle1;

    logic [8:0] dData [2];
    logic       dValid [2], dPerr [2], dFerr [2], dOvr [2], dBrk [2], dIdle [2];

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    expT q [2][$];
    expT ce;
    int  expOv [2], expBrk [2], ovCnt [2], brkCnt [2], words [2];
    logic [8:0] lastData [2];
    logic lastPerr [2], lastFerr [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg dut0 (
        .clk(clk), .rst_n(rstN), .RxD(rxd[0]), .rx_data(data0), .rx_valid(valid0),
        .rx_ready(ready[0]), .parity_err(perr0), .frame_err(ferr0),
        .overrun_err(ovr0), .break_det(brk0), .rx_idle(idle0)
    );

    uart_rx_cfg #(.DataBits(7), .Parity(2), .StopBits(2)) dut1 (
        .clk(clk), .rst_n(rstN), .RxD(rxd[1]), .rx_data(data1), .rx_valid(valid1),
        .rx_ready(ready[1]), .parity_err(perr1), .frame_err(ferr1),
        .overrun_err(ovr1), .break_det(brk1), .rx_idle(idle1)
    );

    assign dData[0] = {1'b0, data0};
    assign dData[1] = {2'b00, data1};
    assign dValid[0] = valid0;  assign dValid[1] = valid1;
    assign dPerr[0]  = perr0;   assign dPerr[1]  = perr1;
    assign dFerr[0]  = ferr0;   assign dFerr[1]  = ferr1;
    assign dOvr[0]   = ovr0;    assign dOvr[1]   = ovr1;
    assign dBrk[0]   = brk0;    assign dBrk[1]   = brk1;
    assign dIdle[0]  = idle0;   assign dIdle[1]  = idle1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every accepted word must match the head of the model queue.
    always @(negedge clk) begin
        if (rstN) begin
            for (int d = 0; d < 2; d++) begin
                if (dValid[d] && ready[d]) begin
                    if (q[d].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word dut%0d: got data 0x%0h, expected no word", d, dData[d]);
                    end else begin
                        int nom, dly;
                        ce = q[d].pop_front();
                        check($sformatf("word_data dut%0d", d), 32'(dData[d]), 32'(ce.data));
                        check($sformatf("word_perr dut%0d", d), 32'(dPerr[d]), 32'(ce.perr));
                        check($sformatf("word_ferr dut%0d", d), 32'(dFerr[d]), 32'(ce.ferr));
                        if (ce.chkLat) begin
                            nom = (OS / 2 + ce.nBits * OS) * DIV;
                            dly = cyc - ce.startCyc;
                            tests++;
                            if (dly < nom - DIV - 2 || dly > nom + 8) begin
                                fails++;
                                $display("FAIL latency dut%0d: got %0d cycles, expected about %0d", d, dly, nom);
                            end
                        end
                        lastData[d] = dData[d];
                        lastPerr[d] = dPerr[d];
                        lastFerr[d] = dFerr[d];
                        words[d]++;
                    end
                end
                if (dOvr[d]) ovCnt[d]++;
                if (dBrk[d]) brkCnt[d]++;
            end
        end
    end

    // Builds a frame, predicts its outcome from the line-level rules, then drives it.
    task automatic sendFrame(input int d, input logic [8:0] val, input int nData, input int parMode,
                             input bit flipPar, input logic s1, input logic s2, input int nStop,
                             input bit chkLat);
        logic [8:0] m;
        logic       pb, ferrE, perrE;
        logic       bits[$];
        expT        e;
        m  = val & ((9'h1 << nData) - 9'h1);
        pb = (parMode == 1) ? ~(^m) : (^m);
        if (flipPar) pb = ~pb;
        perrE = (parMode == 1) ? (((^m) ^ pb) == 1'b0) :
                (parMode == 2) ? (((^m) ^ pb) == 1'b1) : 1'b0;
        ferrE = (s1 == 1'b0) || (nStop == 2 && s2 == 1'b0);
        bits.push_back(1'b0);
        for (int i = 0; i < nData; i++) bits.push_back(m[i]);
        if (parMode != 0) bits.push_back(pb);
        bits.push_back(s1);
        if (nStop == 2) bits.push_back(s2);
        @(negedge clk);
        e.data = m; e.perr = perrE; e.ferr = ferrE; e.startCyc = cyc;
        e.chkLat = chkLat; e.nBits = nData + ((parMode != 0) ? 1 : 0) + nStop;
        if (q[d].size() > 0 && !ready[d]) expOv[d]++;
        else q[d].push_back(e);
        if (m == 9'h0 && (parMode == 0 || pb == 1'b0) && ferrE) expBrk[d]++;
        foreach (bits[i]) begin
            rxd[d] = bits[i];
            repeat (BIT) @(negedge clk);
        end
        rxd[d] = 1'b1;
    endtask

    initial begin
        int w0, w1;
        expT e;
        for (int d = 0; d < 2; d++) begin
            rxd[d] = 1'b1; ready[d] = 1'b1;
            expOv[d] = 0; expBrk[d] = 0; ovCnt[d] = 0; brkCnt[d] = 0; words[d] = 0;
        end
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_data dut%0d", d), 32'(dData[d]), 32'h0);
            check($sformatf("reset_valid dut%0d", d), 32'(dValid[d]), 32'h0);
            check($sformatf("reset_perr dut%0d", d), 32'(dPerr[d]), 32'h0);
            check($sformatf("reset_ferr dut%0d", d), 32'(dFerr[d]), 32'h0);
            check($sformatf("reset_ovr dut%0d", d), 32'(dOvr[d]), 32'h0);
            check($sformatf("reset_brk dut%0d", d), 32'(dBrk[d]), 32'h0);
            check($sformatf("reset_idle dut%0d", d), 32'(dIdle[d]), 32'h0);
        end
        rstN = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("idle_after_reset dut0", 32'(idle0), 32'h1);
        check("idle_after_reset dut1", 32'(idle1), 32'h1);

        // 0xA5 8N1 with rx_ready held high
        sendFrame(0, 9'h0A5, 8, 0, 0, 1'b1, 1'b1, 1, 1);
        repeat (BIT) @(negedge clk);
        $display("[TB] txn A5 8N1: data=0x%0h perr=%0d ferr=%0d", lastData[0], lastPerr[0], lastFerr[0]);
        check("a5_data", 32'(lastData[0]), 32'hA5);
        check("a5_perr", 32'(lastPerr[0]), 32'h0);
        check("a5_ferr", 32'(lastFerr[0]), 32'h0);
        check("a5_words", 32'(words[0]), 32'h1);

        // 0x41 7E2 with good then flipped parity
        sendFrame(1, 9'h041, 7, 2, 0, 1'b1, 1'b1, 2, 1);
        repeat (BIT) @(negedge clk);
        $display("[TB] txn 41 7E2 good parity: data=0x%0h perr=%0d", lastData[1], lastPerr[1]);
        check("p41_good_perr", 32'(lastPerr[1]), 32'h0);
        sendFrame(1, 9'h041, 7, 2, 1, 1'b1, 1'b1, 2, 1);
        repeat (BIT) @(negedge clk);
        $display("[TB] txn 41 7E2 bad parity: data=0x%0h perr=%0d", lastData[1], lastPerr[1]);
        check("p41_bad_perr", 32'(lastPerr[1]), 32'h1);
        check("p41_bad_data", 32'(lastData[1]), 32'h41);

        // Overrun: 0x11 then 0x22 with nobody reading
        ready[0] = 1'b0;
        sendFrame(0, 9'h011, 8, 0, 0, 1'b1, 1'b1, 1, 0);
        repeat (BIT) @(negedge clk);
        sendFrame(0, 9'h022, 8, 0, 0, 1'b1, 1'b1, 1, 0);
        repeat (BIT) @(negedge clk);
        $display("[TB] txn overrun: held=0x%0h valid=%0d overruns=%0d", data0, valid0, ovCnt[0]);
        check("ovr_held_data", 32'(data0), 32'h11);
        check("ovr_valid", 32'(valid0), 32'h1);
        check("ovr_pulses", 32'(ovCnt[0]), 32'h1);
        @(posedge clk);
        #1 ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_cleared", 32'(valid0), 32'h0);
        check("ovr_read_data", 32'(lastData[0]), 32'h11);
        repeat (BIT) @(negedge clk);

        // 3/8-bit low glitch
        w0 = words[0];
        rxd[0] = 1'b0;
        repeat (3 * BIT / 8) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        $display("[TB] txn glitch: words=%0d idle=%0d", words[0], idle0);
        check("glitch_no_word", 32'(words[0]), 32'(w0));
        check("glitch_idle", 32'(idle0), 32'h1);

        // Break: line low for 20 bit times
        @(negedge clk);
        e.data = 9'h0; e.perr = 1'b0; e.ferr = 1'b1; e.startCyc = cyc; e.chkLat = 1; e.nBits = 9;
        q[0].push_back(e);
        expBrk[0]++;
        rxd[0] = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        $display("[TB] txn break: data=0x%0h ferr=%0d breaks=%0d", lastData[0], lastFerr[0], brkCnt[0]);
        check("brk_data", 32'(lastData[0]), 32'h0);
        check("brk_ferr", 32'(lastFerr[0]), 32'h1);
        check("brk_pulses", 32'(brkCnt[0]), 32'h1);
        sendFrame(0, 9'h05A, 8, 0, 0, 1'b1, 1'b1, 1, 1);
        repeat (BIT) @(negedge clk);
        $display("[TB] txn 5A after break: data=0x%0h ferr=%0d", lastData[0], lastFerr[0]);
        check("after_brk_data", 32'(lastData[0]), 32'h5A);
        check("after_brk_ferr", 32'(lastFerr[0]), 32'h0);

        // 7E2 with the second stop bit low
        sendFrame(1, 9'h03C, 7, 2, 0, 1'b1, 1'b0, 2, 1);
        repeat (2 * BIT) @(negedge clk);
        $display("[TB] txn 3C 2nd stop low: data=0x%0h ferr=%0d", lastData[1], lastFerr[1]);
        check("stop2_ferr", 32'(lastFerr[1]), 32'h1);
        check("stop2_data", 32'(lastData[1]), 32'h3C);

        // Reset in the middle of a 0x7F frame's data bits
        w1 = words[1];
        rxd[1] = 1'b0;
        repeat (BIT) @(negedge clk);
        rxd[1] = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_data1", 32'(data1), 32'h0);
        check("midrst_valid1", 32'(valid1), 32'h0);
        check("midrst_ferr1", 32'(ferr1), 32'h0);
        check("midrst_perr1", 32'(perr1), 32'h0);
        check("midrst_idle1", 32'(idle1), 32'h0);
        check("midrst_data0", 32'(data0), 32'h0);
        rstN = 1'b1;
        repeat (6 * BIT) @(negedge clk);
        $display("[TB] txn mid-frame reset: words=%0d valid=%0d", words[1], valid1);
        check("midrst_no_word", 32'(words[1]), 32'(w1));
        sendFrame(1, 9'h02A, 7, 2, 0, 1'b1, 1'b1, 2, 1);
        repeat (BIT) @(negedge clk);
        $display("[TB] txn 2A after reset: data=0x%0h perr=%0d ferr=%0d", lastData[1], lastPerr[1], lastFerr[1]);
        check("post_rst_data", 32'(lastData[1]), 32'h2A);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("pending_words dut%0d", d), 32'(q[d].size()), 32'h0);
            check($sformatf("overrun_count dut%0d", d), 32'(ovCnt[d]), 32'(expOv[d]));
            check($sformatf("break_count dut%0d", d), 32'(brkCnt[d]), 32'(expBrk[d]));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter ClkFrequency, default 24000000, meaning the clk frequency in Hz.
REQ-002 SHALL provide parameter Baud, default 115200, meaning the line bit rate.
REQ-003 SHALL provide parameter Oversampling, default 16, meaning ticks per bit; legal values are 8 and 16.
REQ-004 SHALL provide parameter DataBits, default 8, meaning the data bits per frame; legal values are 5..9.
REQ-005 SHALL provide parameter Parity, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-006 SHALL provide parameter StopBits, default 1, meaning the stop bits checked; legal values are 1 and 2.
REQ-007 SHALL provide port clk, input, 1, the single clock; all logic is rising-edge.
REQ-008 SHALL provide port rst_n, input, 1, the asynchronous active-low reset.
REQ-009 SHALL provide port RxD, input, 1, the asynchronous serial line, idle high.
REQ-010 SHALL provide port rx_data, output, DataBits, the received word, LSB first on the line and right-aligned.
REQ-011 SHALL provide port rx_valid, output, 1, high while rx_data holds an unread word.
REQ-012 SHALL provide port rx_ready, input, 1, the consumer accept signal.
REQ-013 SHALL provide port parity_err, output, 1, the parity status of the word in rx_data.
REQ-014 SHALL provide port frame_err, output, 1, the stop-bit status of the word in rx_data.
REQ-015 SHALL provide port overrun_err, output, 1, a one-cycle pulse when a completed word is dropped.
REQ-016 SHALL provide port break_det, output, 1, a one-cycle pulse on a break condition.
REQ-017 SHALL provide port rx_idle, output, 1, high when no frame has been active for 2 bit times.

Function
REQ-018 SHALL derive tick from a free-running counter dividing by DIV = round(ClkFrequency/(Baud*Oversampling)), with tick high one cycle every DIV clocks.
REQ-019 SHALL synchronise RxD through 2 flops initialised to 1 before any use.
REQ-020 SHALL use a state machine with states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-021 IDLE: a synchronised low moves the FSM to START and clears the per-bit tick counter.
REQ-022 START: on tick count Oversampling/2-1 (mid start bit), if the line is high it SHALL return to IDLE (false start, no output); otherwise it moves to DATA.
REQ-023 DATA: the FSM samples once every Oversampling ticks after the mid-start sample, shifting LSB first; after DataBits samples it moves to PARITY if Parity != 0, else to STOP.
REQ-024 PARITY: the FSM samples one bit; the error is set if XOR(data, bit) is 0 for odd parity or 1 for even parity.
REQ-025 STOP: the FSM samples StopBits bits; frame_err is set if any sampled stop bit is 0.
REQ-026 Completion SHALL occur at the last stop-bit sample, with the FSM returning to IDLE the same cycle; with StopBits = 2 a low first stop bit still samples the second.
REQ-027 On completion with rx_valid = 0, or with rx_valid = 1 and rx_ready = 1 in the same cycle, rx_data, parity_err and frame_err SHALL load on the next edge and rx_valid SHALL be set.
REQ-028 On completion with rx_valid = 1 and rx_ready = 0, the held word SHALL be kept, the new word discarded, and overrun_err pulsed for one cycle.
REQ-029 rx_valid = 1 with rx_ready = 1 and no completion SHALL clear rx_valid on the next edge; rx_data SHALL hold its value.
REQ-030 Break SHALL be a completion with all data bits 0, the parity bit 0 if present, and frame_err set; break_det pulses once, the word is still delivered, and the FSM enters BREAK_WAIT.
REQ-031 BREAK_WAIT SHALL stay until the line is high for one full bit time, then go to IDLE, with no new start detected meanwhile.
REQ-032 rx_idle SHALL be driven by a gap counter in ticks, cleared when not in IDLE and saturating at 2*Oversampling; rx_idle = counter saturated.
REQ-033 Sampling latency SHALL be: rx_valid rises 1 clk after the completion tick.

Reset
REQ-034 rst_n low SHALL asynchronously force the FSM to IDLE, clear all counters, set the synchronisers to 1, set rx_data to 0, clear rx_valid, parity_err, frame_err, overrun_err and break_det, and clear rx_idle.
REQ-035 A reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL restart only on a new falling edge.

Verification
REQ-036 With defaults, sending 0xA5 8N1 with rx_ready held high SHALL give rx_data = 0xA5 with rx_valid high for 1 cycle, and parity_err = 0 and frame_err = 0.
REQ-037 With DataBits = 7 and Parity = 2, sending 0x41 with a correct even parity bit SHALL give parity_err = 0; the same frame with the parity bit flipped SHALL give parity_err = 1 and rx_data = 0x41.
REQ-038 With rx_ready = 0, sending 0x11 then 0x22 SHALL keep rx_data = 0x11 and pulse overrun_err once; raising rx_ready SHALL then clear rx_valid.
REQ-039 A low glitch of 3/8 bit time on RxD SHALL produce no rx_valid and return the FSM to IDLE.
REQ-040 Holding RxD low for 20 bit times, then high, SHALL give rx_data = 0, frame_err = 1, break_det pulsed once, and no second frame; the following frame 0x5A SHALL be received correctly.
REQ-041 With StopBits = 2, if the second stop bit is low, sending 0x3C SHALL give frame_err = 1; asserting rst_n low mid-DATA of the next frame SHALL clear all outputs, and no partial word SHALL appear afterwards.
